// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
// State, excitation encodings ({J,K}) and the default bank width.
package jk_pkg;

  localparam int JK_W_DEFAULT = 4;

  localparam logic [1:0] JK_HOLD  = 2'b00;
  localparam logic [1:0] JK_SET   = 2'b10;
  localparam logic [1:0] JK_RESET = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

endpackage

// File: rtl/jk_excite_bit.sv
// Combinational JK excitation for one flip-flop: maps (current, next) to {J,K}.
// Don't-care entries are resolved to 0 so J=K=1 (toggle) can never appear.
module jk_excite_bit
  import jk_pkg::*;
(
  input  logic       i_cur,
  input  logic       i_nxt,
  output logic [1:0] o_jk
);

  always_comb begin
    o_jk = JK_HOLD;
    if (!i_cur && i_nxt) o_jk = JK_SET;
    else if (i_cur && !i_nxt) o_jk = JK_RESET;
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a W-bit JK flip-flop bank toward requested target words, one-cycle J/K pulse per word.
// Optional readback check of q_fb against the mirror is enabled by JK_DRIVE_VERIFY_EN.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int W     = JK_W_DEFAULT,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic [W-1:0]     j,
  output logic [W-1:0]     k,
  input  logic [W-1:0]     q_fb,
  output logic             done,
  output logic             err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] word_cnt
);

  state_t             r_state, w_state_next;
  logic [W-1:0]       r_j, w_j_next;
  logic [W-1:0]       r_k, w_k_next;
  logic [W-1:0]       r_mirror, w_mirror_next;
  logic [W-1:0]       r_target, w_target_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic               r_done, w_done_next;
  logic [W-1:0]       w_exc_j, w_exc_k;

  // Excitation is always taken against the mirror, which tracks the bank's Q.
  for (genvar gi = 0; gi < W; gi++) begin : g_exc
    logic [1:0] w_jk;
    jk_excite_bit u_bit (
      .i_cur (r_mirror[gi]),
      .i_nxt (in_data[gi]),
      .o_jk  (w_jk)
    );
    assign w_exc_j[gi] = w_jk[1];
    assign w_exc_k[gi] = w_jk[0];
  end

`ifdef JK_DRIVE_VERIFY_EN
  logic r_err, w_err_next;
  assign err = r_err;
`else
  logic w_unused;
  assign w_unused = ^{q_fb, clr_err};
  assign err      = 1'b0;
`endif

  assign in_ready = (r_state == IDLE) && !rst;
  assign j        = r_j;
  assign k        = r_k;
  assign done     = r_done;
  assign word_cnt = r_cnt;

  always_comb begin
    w_state_next  = r_state;
    w_j_next      = '0;
    w_k_next      = '0;
    w_mirror_next = r_mirror;
    w_target_next = r_target;
    w_cnt_next    = r_cnt;
    w_done_next   = 1'b0;
`ifdef JK_DRIVE_VERIFY_EN
    w_err_next    = r_err & ~clr_err;
`endif
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_target_next = in_data;
          w_cnt_next    = r_cnt + 1'b1;
          w_j_next      = w_exc_j;
          w_k_next      = w_exc_k;
          w_state_next  = DRIVE;
        end
      end
      DRIVE: begin
        // The bank samples J/K at this edge, so its Q becomes the target.
        w_mirror_next = r_target;
`ifdef JK_DRIVE_VERIFY_EN
        w_state_next  = CHECK;
`else
        w_state_next  = IDLE;
        w_done_next   = 1'b1;
`endif
      end
`ifdef JK_DRIVE_VERIFY_EN
      CHECK: begin
        if (q_fb != r_mirror) w_err_next = 1'b1;
        w_done_next  = 1'b1;
        w_state_next = IDLE;
      end
`endif
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_j      <= '0;
      r_k      <= '0;
      r_mirror <= '0;
      r_target <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
`ifdef JK_DRIVE_VERIFY_EN
      r_err    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_j      <= w_j_next;
      r_k      <= w_k_next;
      r_mirror <= w_mirror_next;
      r_target <= w_target_next;
      r_cnt    <= w_cnt_next;
      r_done   <= w_done_next;
`ifdef JK_DRIVE_VERIFY_EN
      r_err    <= w_err_next;
`endif
    end
  end

endmodule
